// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for eight requesters sharing one W-bit channel.
// Drives mux select, one-hot grant, registered data and valid, with a burst cap per grant.
module rr_mux_arbiter #(
  parameter int W         = 4,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       req,
  input  logic [8*W-1:0]   din,
  output logic [2:0]       sel,
  output logic [7:0]       gnt,
  output logic [W-1:0]     dout,
  output logic             valid,
  output logic             busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state;
  logic [2:0]  ptr;
  logic [3:0]  cnt;

  logic [2:0]  start;
  logic [15:0] rot_full;
  logic [7:0]  rot;
  logic        found;
  logic [2:0]  widx;
  logic [2:0]  winner;
  logic        release_cond;
  logic [W-1:0] din_win;
  logic [W-1:0] din_cur;

  // A release searches from the slot after the grantee, which is also the new ptr.
  assign start    = (state == GRANT) ? sel + 3'd1 : ptr;
  assign rot_full = {req, req} >> start;
  assign rot      = rot_full[7:0];

  always_comb begin
    found = 1'b0;
    widx  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        widx  = 3'(i);
      end
    end
  end

  assign winner       = start + widx;
  assign release_cond = !req[sel] || (cnt == 4'(MAX_BURST));
  assign din_win      = din[int'(winner)*W +: W];
  assign din_cur      = din[int'(sel)*W +: W];
  assign busy         = |gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 3'd0;
      cnt   <= 4'd0;
      sel   <= 3'd0;
      gnt   <= 8'd0;
      dout  <= '0;
      valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state <= GRANT;
            sel   <= winner;
            gnt   <= 8'd1 << winner;
            dout  <= din_win;
            valid <= 1'b1;
            cnt   <= 4'd1;
          end
        end
        GRANT: begin
          if (!release_cond) begin
            dout  <= din_cur;
            valid <= 1'b1;
            cnt   <= cnt + 4'd1;
          end else begin
            ptr <= sel + 3'd1;
            if (found) begin
              sel   <= winner;
              gnt   <= 8'd1 << winner;
              dout  <= din_win;
              valid <= 1'b1;
              cnt   <= 4'd1;
            end else begin
              state <= IDLE;
              gnt   <= 8'd0;
              valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: stimulus pushes model predictions, a monitor pops and compares.
module tb_rr_mux_arbiter;
  localparam int W = 4;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    req;
  logic [8*W-1:0] din;
  logic [2:0]    sel;
  logic [7:0]    gnt;
  logic [W-1:0]  dout;
  logic          valid;
  logic          busy;

  rr_mux_arbiter #(.W(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .sel(sel), .gnt(gnt), .dout(dout), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [16:0] exp_q[$];

  // Reference model: who owns the channel, for how long, and where the next search begins.
  int m_owner;
  int m_held;
  int m_ptr;
  int m_sel;
  int m_dout;

  function automatic int lane(input logic [8*W-1:0] d, input int i);
    logic [8*W-1:0] s;
    s = d >> (W * i);
    return int'(s[W-1:0]);
  endfunction

  function automatic int first_req(input logic [7:0] r, input int from);
    for (int k = 0; k < 8; k++) begin
      if (r[(from + k) % 8]) return (from + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_ptr = 0; m_sel = 0; m_dout = 0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic [8*W-1:0] d);
    int w;
    if (m_owner < 0) begin
      w = first_req(r, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_held = 1; m_sel = w; m_dout = lane(d, w);
      end
    end else if (r[m_owner] && m_held < MB) begin
      m_held++;
      m_dout = lane(d, m_owner);
    end else begin
      m_ptr = (m_owner + 1) % 8;
      w = first_req(r, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_held = 1; m_sel = w; m_dout = lane(d, w);
      end else begin
        m_owner = -1;
      end
    end
  endtask

  function automatic logic [16:0] model_out();
    logic [7:0] g;
    g = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
    return {3'(m_sel), g, 4'(m_dout), (m_owner >= 0), (m_owner >= 0)};
  endfunction

  task automatic step(input logic [7:0] r, input logic [8*W-1:0] d);
    @(negedge clk);
    req = r;
    din = d;
    model_step(r, d);
    exp_q.push_back(model_out());
    @(posedge clk);
  endtask

  task automatic check_zero(input string name);
    total++;
    if ({sel, gnt, dout, valid, busy} !== 17'd0) begin
      bad++;
      $display("FAIL %s: got sel=%0d gnt=%b dout=%0d valid=%b busy=%b, want all zero",
               name, sel, gnt, dout, valid, busy);
    end
  endtask

  // Monitor: one comparison per predicted cycle, sampled just after the active edge.
  initial begin
    logic [16:0] e;
    logic [16:0] a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {sel, gnt, dout, valid, busy};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL cycle t=%0t: got sel=%0d gnt=%b dout=%0d valid=%b busy=%b, want sel=%0d gnt=%b dout=%0d valid=%b busy=%b",
                   $time, a[16:14], a[13:6], a[5:2], a[1], a[0], e[16:14], e[13:6], e[5:2], e[1], e[0]);
        end else begin
          $display("txn t=%0t req=%b sel=%0d gnt=%b dout=%0d valid=%b", $time, req, sel, gnt, dout, valid);
        end
      end
    end
  end

  initial begin
    logic [8*W-1:0] lanes;
    logic [7:0] r;
    for (int i = 0; i < 8; i++) lanes[i*W +: W] = 4'(i);
    rst_n = 1'b0;
    req   = 8'h00;
    din   = lanes;
    model_reset();
    #2;
    check_zero("reset_async");
    @(negedge clk);
    rst_n = 1'b1;

    repeat (5) step(8'h00, lanes);
    repeat (24) step(8'b0010_0100, lanes);
    repeat (2) step(8'h80, lanes);
    repeat (2) step(8'h00, lanes);
    repeat (3) step(8'h01, lanes);
    repeat (64) step(8'hFF, lanes);
    repeat (20) step(8'h08, lanes);
    repeat (2) step(8'h00, lanes);
    repeat (2) step(8'h10, lanes);

    // Mid-burst reset away from any edge: outputs must clear immediately.
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_burst");
    model_reset();
    req = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) step(8'h30, lanes);

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: r = 8'(1 << $urandom_range(0, 7));
        1: r = 8'($urandom) & 8'($urandom);
        2: r = 8'($urandom) | 8'($urandom);
        default: r = 8'($urandom);
      endcase
      if ($urandom_range(0, 9) == 0) r = 8'h00;
      step(r, 32'($urandom));
    end

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and select controller for the 8:1 x 4-bit mux datapath.
- Eight requesters share one 4-bit output channel. The block picks a winner, drives the mux select and a one-hot grant, and registers the selected data with a valid flag.
- A burst limit caps how long one requester may hold the channel, so no requester starves.

Parameters:
- W, 4, data width per requester.
- MAX_BURST, 4, maximum consecutive cycles one grant may be held (legal range 1..15).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  8  request per requester; bit i = requester i.
- din  input  8*W  packed data; requester i at din[i*W +: W].
- sel  output  3  mux select, index of current/last grantee.
- gnt  output  8  one-hot grant; all zero when idle.
- dout  output  W  registered data of granted requester.
- valid  output  1  dout carries granted data this cycle.
- busy  output  1  high in GRANT state (equals |gnt).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values (rst_n low, immediate, no clock needed):
  - sel=0, gnt=0, dout=0, valid=0, busy=0.
  - Internal priority pointer ptr=0, burst counter cnt=0, state=IDLE.
- Winner search:
  - Scan indices ptr, ptr+1, ... mod 8.
  - The first index with req set wins; exactly one winner.
  - Wrap-around: after index 7 the scan continues at 0.
- IDLE state:
  - If req==0, all outputs hold; gnt=0, valid=0; dout keeps its last value.
  - If req!=0, on the next rising edge: state->GRANT, sel<=winner, gnt<=onehot(winner), dout<=din[winner], valid<=1, cnt<=1.
  - Latency: req sampled at edge k gives valid/dout at edge k (registered outputs visible after edge k).
- GRANT state, evaluated each rising edge with current grantee g=sel. Release condition R = (req[g]==0) or (cnt==MAX_BURST).
  - If not R: hold g, dout<=din[g] (tracks live data), valid<=1, cnt<=cnt+1.
  - If R: ptr<=(g+1) mod 8, then search for a new winner from (g+1) mod 8 in the same cycle (no idle bubble).
    - If a winner w is found (may equal g if only g still requests): sel<=w, gnt<=onehot(w), dout<=din[w], valid<=1, cnt<=1.
    - If no requests: state->IDLE, gnt<=0, valid<=0, sel and dout hold.
- Simultaneous events:
  - Several requests arriving together in IDLE are resolved by ptr order.
  - When the grantee drops req while others request, handoff happens at that edge.
  - A request that rises in the same cycle as a release is eligible for that search.
- Fairness: within 8*MAX_BURST cycles, every continuously asserted requester receives a grant.
- Reset mid-grant: all state and outputs clear at once; ptr returns to 0. After release, arbitration restarts as from power-up.
- cnt is never greater than MAX_BURST.

Test Plan:
- Data setup: din lane i = i (4'd0..4'd7).
- Reset then req=8'h00 for 5 cycles -> gnt=0, valid=0, sel=0, dout=0, busy=0.
- req=8'b0010_0100 held -> grant 2 (dout=2, sel=2) for 4 cycles. Then grant 5 (dout=5) for 4 cycles. Then back to 2; no idle cycle between grants.
- req=8'h80 single pulse of 2 cycles -> sel=7, dout=7, valid high for 2 cycles, then IDLE with valid=0. Next req=8'h01 -> grant 0 (ptr wrapped to 0).
- req=8'hFF held for 64 cycles -> grant order 0,1,...,7,0, each held exactly MAX_BURST=4 cycles; gnt always one-hot.
- Only req[3] held continuously -> grant 3 re-issued after each 4-cycle burst with no gap; valid stays 1.
- Drop rst_n mid-burst (grantee 4, cnt=2) -> outputs clear without a clock edge. Release with req=8'h30 -> grant 4 first (ptr=0 scan).
